// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection,
// bubble insertion and EX-stage operand forwarding.
//
// Ports
//   clk, rst                      clock, async active-high reset
//   id_*                          decoded instruction fields from ID
//   flush                         kill the instruction entering EX
//   hold                          freeze EX contents (downstream stall)
//   mem_fwd_en/mem_rd/mem_result  EX/MEM forwarding source
//   wb_fwd_en/wb_rd/wb_result     MEM/WB forwarding source
//   stall                         freeze PC and IF/ID this cycle
//   ex_valid, ex_alu_control      registered valid and ALU code
//   ex_a, ex_b                    forwarded, selected ALU operands
//   ex_store_data                 forwarded rs2 (store data)
//   ex_rd, ex_reg_write,
//   ex_mem_read                   registered destination and control
module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_alu_control,
  input  logic [1:0]  id_src_a,
  input  logic        id_src_b,
  input  logic [4:0]  id_rd,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        flush,
  input  logic        hold,
  input  logic        mem_fwd_en,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_result,
  input  logic        wb_fwd_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_result,
  output logic        stall,
  output logic        ex_valid,
  output logic [4:0]  ex_alu_control,
  output logic [31:0] ex_a,
  output logic [31:0] ex_b,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_write,
  output logic        ex_mem_read
);

  logic [31:0] ex_pc;
  logic [4:0]  ex_rs1_addr;
  logic [4:0]  ex_rs2_addr;
  logic [31:0] ex_rs1_data;
  logic [31:0] ex_rs2_data;
  logic [31:0] ex_imm;
  logic [1:0]  ex_src_a;
  logic        ex_src_b;

  logic        load_use;
  logic        bubble;
  logic [31:0] rs1_fwd;
  logic [31:0] rs2_fwd;

  // Conservative: any source index match counts, even if the ID
  // instruction does not actually read that operand.
  assign load_use = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid &
                    ((id_rs1_addr == ex_rd) | (id_rs2_addr == ex_rd));

  assign stall  = ~flush & (hold | load_use);
  assign bubble = flush | (~hold & load_use);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid       <= 1'b0;
      ex_pc          <= '0;
      ex_rs1_addr    <= '0;
      ex_rs2_addr    <= '0;
      ex_rs1_data    <= '0;
      ex_rs2_data    <= '0;
      ex_imm         <= '0;
      ex_alu_control <= '0;
      ex_src_a       <= '0;
      ex_src_b       <= 1'b0;
      ex_rd          <= '0;
      ex_reg_write   <= 1'b0;
      ex_mem_read    <= 1'b0;
    end else if (bubble) begin
      // Clear the whole entry so a bubble presents zero operands too.
      ex_valid       <= 1'b0;
      ex_pc          <= '0;
      ex_rs1_addr    <= '0;
      ex_rs2_addr    <= '0;
      ex_rs1_data    <= '0;
      ex_rs2_data    <= '0;
      ex_imm         <= '0;
      ex_alu_control <= '0;
      ex_src_a       <= '0;
      ex_src_b       <= 1'b0;
      ex_rd          <= '0;
      ex_reg_write   <= 1'b0;
      ex_mem_read    <= 1'b0;
    end else if (!hold) begin
      ex_valid       <= id_valid;
      ex_pc          <= id_pc;
      ex_rs1_addr    <= id_rs1_addr;
      ex_rs2_addr    <= id_rs2_addr;
      ex_rs1_data    <= id_rs1_data;
      ex_rs2_data    <= id_rs2_data;
      ex_imm         <= id_imm;
      ex_src_a       <= id_src_a;
      ex_src_b       <= id_src_b;
      // An invalid ID slot must never look like a write or a load.
      ex_alu_control <= id_valid ? id_alu_control : 5'd0;
      ex_rd          <= id_valid ? id_rd : 5'd0;
      ex_reg_write   <= id_valid & id_reg_write;
      ex_mem_read    <= id_valid & id_mem_read;
    end
  end

  // x0 is never forwarded; MEM is the younger result so it wins over WB.
  function automatic logic [31:0] fwd(
    input logic [4:0]  addr,
    input logic [31:0] data,
    input logic        m_en,
    input logic [4:0]  m_rd,
    input logic [31:0] m_res,
    input logic        w_en,
    input logic [4:0]  w_rd,
    input logic [31:0] w_res
  );
    if (addr == 5'd0)               return 32'd0;
    else if (m_en && (m_rd == addr)) return m_res;
    else if (w_en && (w_rd == addr)) return w_res;
    else                             return data;
  endfunction

  always_comb begin
    rs1_fwd = fwd(ex_rs1_addr, ex_rs1_data, mem_fwd_en, mem_rd, mem_result,
                  wb_fwd_en, wb_rd, wb_result);
    rs2_fwd = fwd(ex_rs2_addr, ex_rs2_data, mem_fwd_en, mem_rd, mem_result,
                  wb_fwd_en, wb_rd, wb_result);
  end

  always_comb begin
    ex_a = 32'd0;
    case (ex_src_a)
      2'b00:   ex_a = rs1_fwd;
      2'b01:   ex_a = ex_pc;
      default: ex_a = 32'd0;
    endcase
  end

  assign ex_b          = ex_src_b ? ex_imm : rs2_fwd;
  assign ex_store_data = rs2_fwd;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic [31:0] id_imm;
  logic [4:0]  id_alu_control;
  logic [1:0]  id_src_a;
  logic        id_src_b;
  logic [4:0]  id_rd;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        flush;
  logic        hold;
  logic        mem_fwd_en;
  logic [4:0]  mem_rd;
  logic [31:0] mem_result;
  logic        wb_fwd_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;
  logic        stall;
  logic        ex_valid;
  logic [4:0]  ex_alu_control;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_mem_read;

  int checks = 0;
  int errors = 0;

  id_ex_stage dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_rs1_addr    (id_rs1_addr),
    .id_rs2_addr    (id_rs2_addr),
    .id_rs1_data    (id_rs1_data),
    .id_rs2_data    (id_rs2_data),
    .id_imm         (id_imm),
    .id_alu_control (id_alu_control),
    .id_src_a       (id_src_a),
    .id_src_b       (id_src_b),
    .id_rd          (id_rd),
    .id_reg_write   (id_reg_write),
    .id_mem_read    (id_mem_read),
    .flush          (flush),
    .hold           (hold),
    .mem_fwd_en     (mem_fwd_en),
    .mem_rd         (mem_rd),
    .mem_result     (mem_result),
    .wb_fwd_en      (wb_fwd_en),
    .wb_rd          (wb_rd),
    .wb_result      (wb_result),
    .stall          (stall),
    .ex_valid       (ex_valid),
    .ex_alu_control (ex_alu_control),
    .ex_a           (ex_a),
    .ex_b           (ex_b),
    .ex_store_data  (ex_store_data),
    .ex_rd          (ex_rd),
    .ex_reg_write   (ex_reg_write),
    .ex_mem_read    (ex_mem_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  r1a;
    logic [4:0]  r2a;
    logic [31:0] r1d;
    logic [31:0] r2d;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  alu;
    logic [1:0]  sa;
    logic        sb;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        fl;
    logic        ho;
    logic        mfe;
    logic [4:0]  mrd;
    logic [31:0] mres;
    logic        wfe;
    logic [4:0]  wrd;
    logic [31:0] wres;
    logic        e_stall;
    logic        e_v;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic [31:0] e_sd;
    logic [4:0]  e_rd;
    logic        e_rw;
    logic        e_mr;
    logic [4:0]  e_alu;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_vec(input vec_t t);
    id_valid       = t.v;
    id_rs1_addr    = t.r1a;
    id_rs2_addr    = t.r2a;
    id_rs1_data    = t.r1d;
    id_rs2_data    = t.r2d;
    id_imm         = t.imm;
    id_pc          = t.pc;
    id_alu_control = t.alu;
    id_src_a       = t.sa;
    id_src_b       = t.sb;
    id_rd          = t.rd;
    id_reg_write   = t.rw;
    id_mem_read    = t.mr;
    flush          = t.fl;
    hold           = t.ho;
    mem_fwd_en     = t.mfe;
    mem_rd         = t.mrd;
    mem_result     = t.mres;
    wb_fwd_en      = t.wfe;
    wb_rd          = t.wrd;
    wb_result      = t.wres;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_data = 0;
    id_rs2_data = 0; id_imm = 0; id_pc = 0; id_alu_control = 0;
    id_src_a = 0; id_src_b = 0; id_rd = 0; id_reg_write = 0;
    id_mem_read = 0; flush = 0; hold = 0; mem_fwd_en = 0; mem_rd = 0;
    mem_result = 0; wb_fwd_en = 0; wb_rd = 0; wb_result = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " ex_valid"}, 32'(ex_valid), 0);
    chk({tag, " ex_alu"}, 32'(ex_alu_control), 0);
    chk({tag, " ex_a"}, ex_a, 0);
    chk({tag, " ex_b"}, ex_b, 0);
    chk({tag, " ex_sd"}, ex_store_data, 0);
    chk({tag, " ex_rd"}, 32'(ex_rd), 0);
    chk({tag, " ex_rw"}, 32'(ex_reg_write), 0);
    chk({tag, " ex_mr"}, 32'(ex_mem_read), 0);
  endtask

  initial begin
    // order: v r1a r2a r1d r2d imm pc alu sa sb rd rw mr fl ho |
    //        mfe mrd mres wfe wrd wres | stall v a b sd rd rw mr alu
    // add x3,x1,x2
    vecs[0]  = '{1,1,2,5,7,0,'h10,0,0,0,3,1,0,0,0, 0,0,0,0,0,0,
                 0,1,5,7,7,3,1,0,0};
    // pc / imm operand selection, x0 never forwarded into store data path
    vecs[1]  = '{1,0,6,0,9,'hFFFFFFFC,'h100,1,1,1,7,1,0,0,0, 1,0,'hFFFF,0,0,0,
                 0,1,'h100,'hFFFFFFFC,9,7,1,0,1};
    // rs1=x0 with MEM targeting x0 -> 0; rs2 forwarded from WB
    vecs[2]  = '{1,0,4,0,1,0,'h14,2,0,0,8,1,0,0,0, 1,0,'hFFFF,1,4,'h22,
                 0,1,0,'h22,'h22,8,1,0,2};
    // MEM beats WB on equal rd
    vecs[3]  = '{1,4,5,3,'h55,0,'h18,3,0,0,9,1,0,0,0, 1,4,'hAA,1,4,'hBB,
                 0,1,'hAA,'h55,'h55,9,1,0,3};
    // invalid ID: control forced to zero, data still captured
    vecs[4]  = '{0,1,2,'h11,'h22,0,'h1C,4,0,0,10,1,1,0,0, 0,0,0,0,0,0,
                 0,0,'h11,'h22,'h22,0,0,0,0};
    // load x5
    vecs[5]  = '{1,1,0,'h1000,0,4,'h20,0,0,1,5,1,1,0,0, 0,0,0,0,0,0,
                 0,1,'h1000,4,0,5,1,1,0};
    // uses x5 in rs2 -> stall, bubble
    vecs[6]  = '{1,1,5,1,'h77,0,'h24,0,0,0,6,1,0,0,0, 0,0,0,0,0,0,
                 1,0,0,0,0,0,0,0,0};
    // same instruction retried -> captured, no stall
    vecs[7]  = '{1,1,5,1,'h77,0,'h24,0,0,0,6,1,0,0,0, 0,0,0,0,0,0,
                 0,1,1,'h77,'h77,6,1,0,0};
    // load x5 again
    vecs[8]  = '{1,2,0,'h2000,0,8,'h28,0,0,1,5,1,1,0,0, 0,0,0,0,0,0,
                 0,1,'h2000,8,0,5,1,1,0};
    // load-use together with flush -> no stall, bubble
    vecs[9]  = '{1,5,0,3,0,0,'h2C,0,0,0,7,1,0,1,0, 0,0,0,0,0,0,
                 0,0,0,0,0,0,0,0,0};
    // after bubble, dependent instruction enters freely
    vecs[10] = '{1,5,0,3,0,0,'h2C,0,0,0,7,1,0,0,0, 0,0,0,0,0,0,
                 0,1,3,0,0,7,1,0,0};

    idle_inputs();
    rst = 1'b1;
    #12;
    chk_all_zero("reset");
    chk("reset stall", 32'(stall), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive_vec(vecs[i]);
      #1;
      chk($sformatf("v%0d stall", i), 32'(stall), 32'(vecs[i].e_stall));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d ex_valid", i), 32'(ex_valid), 32'(vecs[i].e_v));
      chk($sformatf("v%0d ex_a", i), ex_a, vecs[i].e_a);
      chk($sformatf("v%0d ex_b", i), ex_b, vecs[i].e_b);
      chk($sformatf("v%0d ex_sd", i), ex_store_data, vecs[i].e_sd);
      chk($sformatf("v%0d ex_rd", i), 32'(ex_rd), 32'(vecs[i].e_rd));
      chk($sformatf("v%0d ex_rw", i), 32'(ex_reg_write), 32'(vecs[i].e_rw));
      chk($sformatf("v%0d ex_mr", i), 32'(ex_mem_read), 32'(vecs[i].e_mr));
      chk($sformatf("v%0d ex_alu", i), 32'(ex_alu_control), 32'(vecs[i].e_alu));
      @(negedge clk);
    end

    // load-use while held: hold keeps the load in EX, then one bubble
    idle_inputs();
    id_valid = 1; id_rs1_addr = 1; id_rs1_data = 'h40; id_src_b = 1;
    id_rd = 5; id_reg_write = 1; id_mem_read = 1;
    @(posedge clk); @(negedge clk);
    id_rs1_addr = 5; id_rd = 6; id_mem_read = 0; id_src_b = 0; hold = 1;
    #1 chk("lu_hold stall", 32'(stall), 1);
    @(posedge clk); #1;
    chk("lu_hold ex_mr", 32'(ex_mem_read), 1);
    chk("lu_hold ex_rd", 32'(ex_rd), 5);
    chk("lu_hold ex_valid", 32'(ex_valid), 1);
    @(negedge clk);
    hold = 0;
    #1 chk("lu stall", 32'(stall), 1);
    @(posedge clk); #1;
    chk("lu bubble valid", 32'(ex_valid), 0);
    chk("lu bubble rw", 32'(ex_reg_write), 0);
    @(negedge clk);
    #1 chk("lu after stall", 32'(stall), 0);
    @(posedge clk); #1;
    chk("lu capture rd", 32'(ex_rd), 6);
    chk("lu capture valid", 32'(ex_valid), 1);
    chk("lu capture a", ex_a, 'h40);

    // forwarding priority live during hold, then async reset mid-hold
    @(negedge clk);
    idle_inputs();
    id_valid = 1; id_rs1_addr = 4; id_rs1_data = 1; id_rd = 9; id_reg_write = 1;
    @(posedge clk); @(negedge clk);
    hold = 1; id_rs1_addr = 2; id_rd = 12;
    mem_fwd_en = 1; mem_rd = 4; mem_result = 'hAA;
    wb_fwd_en = 1; wb_rd = 4; wb_result = 'hBB;
    #1;
    chk("hold stall", 32'(stall), 1);
    chk("fwd mem", ex_a, 'hAA);
    mem_fwd_en = 0;
    #1 chk("fwd wb", ex_a, 'hBB);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d ex_rd", c), 32'(ex_rd), 9);
      chk($sformatf("hold%0d ex_valid", c), 32'(ex_valid), 1);
      chk($sformatf("hold%0d ex_a", c), ex_a, 'hBB);
      chk($sformatf("hold%0d stall", c), 32'(stall), 1);
    end
    #1 rst = 1'b1; hold = 0;
    #1;
    chk_all_zero("midhold rst");
    chk("midhold rst stall", 32'(stall), 0);
    #1 rst = 1'b0;
    @(negedge clk);
    id_valid = 1; id_rs1_addr = 1; id_rs1_data = 'h33; id_rd = 2;
    @(posedge clk); #1;
    chk("post rst ex_a", ex_a, 'h33);
    chk("post rst ex_rd", 32'(ex_rd), 2);
    chk("post rst ex_valid", 32'(ex_valid), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
